// File: rtl/div_unit.sv
// Multicycle radix-2 restoring divider with MIPS DIV semantics: quotient to LO, remainder to HI.
// Optional macro DIV_UNSIGNED_EN adds an unsigned_op input that selects DIVU behaviour.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNSIGNED_EN
    input  logic             unsigned_op,
`endif
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;

    logic             op_unsigned;
    logic             dd_neg, dv_neg;
    logic [WIDTH-1:0] dd_mag, dv_mag;
    logic [WIDTH:0]   shifted, trial;

`ifdef DIV_UNSIGNED_EN
    assign op_unsigned = unsigned_op;
`else
    assign op_unsigned = 1'b0;
`endif

    always_comb begin
        dd_neg  = ~op_unsigned & dividend[WIDTH-1];
        dv_neg  = ~op_unsigned & divisor[WIDTH-1];
        dd_mag  = dd_neg ? (~dividend + 1'b1) : dividend;
        dv_mag  = dv_neg ? (~divisor + 1'b1) : divisor;
        // remainder < divisor always, so a non-negative trial never sets bit WIDTH
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (divisor == '0) ? DONE : CALC;
            CALC: if (cnt_q == LAST) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        cnt_d  = cnt_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        rem_d  = '0;
                        quo_d  = dd_mag;
                        dvs_d  = dv_mag;
                        cnt_d  = '0;
                        rneg_d = dd_neg;
                        qneg_d = dd_neg ^ dv_neg;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
            end
            FIX: begin
                lo_d = qneg_q ? (~quo_q + 1'b1) : quo_q;
                hi_d = rneg_q ? (~rem_q + 1'b1) : rem_q;
            end
            DONE: dz_d = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        div_zero = (state_q == DONE) & dz_q;
        hi_out   = hi_q;
        lo_out   = lo_q;
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized bench for div_unit: a cycle-level behavioural model built on 64-bit arithmetic,
// a per-cycle compare process, and directed literal checks for the documented cases.
module tb_div_unit;
    localparam int WIDTH = 32;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [31:0] dividend, divisor;
    logic        unsigned_op = 1'b0;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_zero;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    div_unit #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .start(start),
        .dividend(dividend), .divisor(divisor),
`ifdef DIV_UNSIGNED_EN
        .unsigned_op(unsigned_op),
`endif
        .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result {remainder, quotient} using wide integer division.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic uo);
        longint sa, sb, q, r;
        if (uo) begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Timing model: done lands WIDTH+1 edges after acceptance, or on the accept edge for /0.
    logic        m_busy, m_done, m_dz;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;

    always @(posedge clock) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_left <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                if (divisor == 32'd0) begin
                    m_done <= 1'b1;
                    m_dz   <= 1'b1;
                end else begin
                    m_left <= WIDTH + 1;
                    {p_hi, p_lo} <= ref_div(dividend, divisor, unsigned_op);
                end
            end
        end else if (m_done) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_hi   <= p_hi;
                m_lo   <= p_lo;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
            chk("cyc_done", {31'b0, done}, {31'b0, m_done});
            chk("cyc_div_zero", {31'b0, div_zero}, {31'b0, m_dz});
            chk("cyc_hi", hi_out, m_hi);
            chk("cyc_lo", lo_out, m_lo);
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic uo,
                          output int lat, output logic dz);
        @(negedge clock);
        dividend = a; divisor = b; unsigned_op = uo; start = 1'b1;
        lat = 0; dz = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            if (k == 1) begin
                start = 1'b0;
                dividend = $urandom;
                divisor  = $urandom;
                chk("busy_after_accept", {31'b0, busy}, 32'd1);
            end
            if (done) begin
                lat = k;
                dz  = div_zero;
                break;
            end
        end
        if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int          lat, ndone;
    logic        dz;
    logic [31:0] ra, rb;

    initial begin
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        @(negedge clock);
        chk_en = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        chk("rst_flags", {29'b0, busy, done, div_zero}, 32'd0);

        run_op(32'd7, 32'd2, 1'b0, lat, dz);
        chk("lat_7_2", lat, 32'd34);
        chk("lo_7_2", lo_out, 32'd3);
        chk("hi_7_2", hi_out, 32'd1);

        run_op(32'd7, 32'd0, 1'b0, lat, dz);
        chk("lat_div0", lat, 32'd1);
        chk("dz_div0", {31'b0, dz}, 32'd1);
        chk("lo_div0_hold", lo_out, 32'd3);
        chk("hi_div0_hold", hi_out, 32'd1);
        @(negedge clock);
        chk("busy_after_div0", {31'b0, busy}, 32'd0);

        run_op(32'hFFFFFFF9, 32'd2, 1'b0, lat, dz);
        chk("lo_m7_2", lo_out, 32'hFFFFFFFD);
        chk("hi_m7_2", hi_out, 32'hFFFFFFFF);
        run_op(32'd7, 32'hFFFFFFFE, 1'b0, lat, dz);
        chk("lo_7_m2", lo_out, 32'hFFFFFFFD);
        chk("hi_7_m2", hi_out, 32'd1);

        run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, lat, dz);
        chk("lo_ovf", lo_out, 32'h80000000);
        chk("hi_ovf", hi_out, 32'd0);
        chk("dz_ovf", {31'b0, dz}, 32'd0);

        // start pulsed mid-operation must be ignored
        @(negedge clock);
        dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        lat = 0; ndone = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            start = (k == 10);
            if (k == 10) begin dividend = 32'd5; divisor = 32'd1; end
            if (done) begin
                ndone++;
                if (lat == 0) lat = k;
            end
        end
        chk("lat_restart", lat, 32'd34);
        chk("ndone_restart", ndone, 32'd1);
        chk("lo_1000_3", lo_out, 32'd333);
        chk("hi_1000_3", hi_out, 32'd1);

        // reset mid-operation discards the in-flight result
        @(negedge clock);
        dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (k == 20) reset = 1'b1;
            if (k == 21) begin
                reset = 1'b0;
                chk("rst_mid_hi", hi_out, 32'd0);
                chk("rst_mid_lo", lo_out, 32'd0);
                chk("rst_mid_flags", {29'b0, busy, done, div_zero}, 32'd0);
            end
            if (done) ndone++;
        end
        chk("ndone_after_reset", ndone, 32'd0);
        run_op(32'd100, 32'd7, 1'b0, lat, dz);
        chk("lo_100_7", lo_out, 32'd14);
        chk("hi_100_7", hi_out, 32'd2);

`ifdef DIV_UNSIGNED_EN
        run_op(32'hFFFFFFFE, 32'd2, 1'b1, lat, dz);
        chk("lo_divu", lo_out, 32'h7FFFFFFF);
        chk("hi_divu", hi_out, 32'd0);
        run_op(32'hFFFFFFFE, 32'd2, 1'b0, lat, dz);
        chk("lo_div_s", lo_out, 32'hFFFFFFFF);
        chk("hi_div_s", hi_out, 32'd0);
`endif

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: ra = $urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = $urandom_range(1, 9);
                default: rb = $urandom;
            endcase
`ifdef DIV_UNSIGNED_EN
            run_op(ra, rb, 1'($urandom_range(0, 1)), lat, dz);
`else
            run_op(ra, rb, 1'b0, lat, dz);
`endif
            chk("rand_lat", lat, (rb == 32'd0) ? 32'd1 : 32'd34);
        end

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
